// File: rtl/axil_ext_regs_pkg.sv
// Shared types and constants for the AXI-lite external registers bridge.
// Contents:
//   write_state_t  - write-side FSM states
//   read_state_t   - read-side FSM states
//   RESP_OKAY / RESP_SLVERR - AXI response codes
package axil_ext_regs_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_STREAM  = 2'd2,
    W_RESP    = 2'd3
  } write_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } read_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_ext_regs_addr_decode.sv
// Combinational byte address -> register index decoder for the bridge window.
// Ports:
//   addr  in  32          AXI byte address
//   index out DEST_WIDTH  register index, (addr - BASE_ADDRESS) >> 2
//   error out 1           misaligned, below the window or past its last word
module axil_ext_regs_addr_decode #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h0,
  parameter int          NUM_REGISTERS = 3,
  parameter int          DEST_WIDTH    = 8
) (
  input  logic [31:0]           addr,
  output logic [DEST_WIDTH-1:0] index,
  output logic                  error
);

  logic [31:0] offset;
  logic [31:0] word;

  always_comb begin
    offset = addr - BASE_ADDRESS;
    word   = {2'b00, offset[31:2]};
    index  = word[DEST_WIDTH-1:0];
    // BASE_ADDRESS is word aligned, so offset[1:0] equals addr[1:0].
    error  = (offset[1:0] != 2'b00) || (addr < BASE_ADDRESS) ||
             (word >= 32'(NUM_REGISTERS));
  end

endmodule

// File: rtl/axil_external_registers_bridge.sv
// AXI-lite slave exposing NUM_REGISTERS 32-bit words as external registers.
// Writes leave as write_data beats (dest = index); reads send the index on
// read_address and return the reply taken from read_data.
// Ports:
//   clock, reset            clock; synchronous active-low reset
//   axi_in_*                AXI-lite slave (AW/W/B/AR/R)
//   write_data_*            stream master: data = WDATA, dest = index
//   read_address_*          stream master: data = index
//   read_data_*             stream slave: register value reply
//   write_state/read_state  current FSM states (debug)
// Handshake rule: every channel transfers on a clock edge where valid and
// ready are both high; a source holds valid and payload stable until then.
// Optional feature: define AXIL_EXT_REGS_READ_TIMEOUT_EN to bound the wait
// for read_data to TIMEOUT_CYCLES clocks (SLVERR on expiry).
module axil_external_registers_bridge
  import axil_ext_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0,
  parameter int          NUM_REGISTERS  = 3,
  parameter int          DEST_WIDTH     = 8,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  axi_in_awvalid,
  output logic                  axi_in_awready,
  input  logic [31:0]           axi_in_awaddr,
  input  logic                  axi_in_wvalid,
  output logic                  axi_in_wready,
  input  logic [31:0]           axi_in_wdata,
  input  logic [3:0]            axi_in_wstrb,
  output logic                  axi_in_bvalid,
  input  logic                  axi_in_bready,
  output logic [1:0]            axi_in_bresp,
  input  logic                  axi_in_arvalid,
  output logic                  axi_in_arready,
  input  logic [31:0]           axi_in_araddr,
  output logic                  axi_in_rvalid,
  input  logic                  axi_in_rready,
  output logic [31:0]           axi_in_rdata,
  output logic [1:0]            axi_in_rresp,
  output logic                  write_data_valid,
  input  logic                  write_data_ready,
  output logic [31:0]           write_data_data,
  output logic [DEST_WIDTH-1:0] write_data_dest,
  output logic                  read_address_valid,
  input  logic                  read_address_ready,
  output logic [DEST_WIDTH-1:0] read_address_data,
  input  logic                  read_data_valid,
  output logic                  read_data_ready,
  input  logic [31:0]           read_data_data,
  output write_state_t          write_state,
  output read_state_t           read_state
);

  logic [DEST_WIDTH-1:0] aw_dec_index, ar_dec_index;
  logic                  aw_dec_error, ar_dec_error;

  axil_ext_regs_addr_decode #(.BASE_ADDRESS(BASE_ADDRESS), .NUM_REGISTERS(NUM_REGISTERS),
                              .DEST_WIDTH(DEST_WIDTH))
    u_aw_decode (.addr(axi_in_awaddr), .index(aw_dec_index), .error(aw_dec_error));

  axil_ext_regs_addr_decode #(.BASE_ADDRESS(BASE_ADDRESS), .NUM_REGISTERS(NUM_REGISTERS),
                              .DEST_WIDTH(DEST_WIDTH))
    u_ar_decode (.addr(axi_in_araddr), .index(ar_dec_index), .error(ar_dec_error));

  // ---------------- write side ----------------
  write_state_t          w_state_n;
  logic                  awready_n, wready_n, bvalid_n, wd_valid_n;
  logic [1:0]            bresp_n;
  logic [31:0]           wd_data_n, wdata_q, wdata_n;
  logic [DEST_WIDTH-1:0] wd_dest_n, aw_index_q, aw_index_n;
  logic [3:0]            wstrb_q, wstrb_n;
  logic                  aw_have_q, aw_have_n, w_have_q, w_have_n;
  logic                  aw_error_q, aw_error_n;

  always_comb begin
    w_state_n  = write_state;
    awready_n  = axi_in_awready;
    wready_n   = axi_in_wready;
    bvalid_n   = axi_in_bvalid;
    bresp_n    = axi_in_bresp;
    wd_valid_n = write_data_valid;
    wd_data_n  = write_data_data;
    wd_dest_n  = write_data_dest;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    aw_index_n = aw_index_q;
    aw_error_n = aw_error_q;
    aw_have_n  = aw_have_q;
    w_have_n   = w_have_q;
    case (write_state)
      W_IDLE, W_COLLECT: begin
        if (axi_in_awvalid && axi_in_awready) begin
          aw_have_n  = 1'b1;
          aw_index_n = aw_dec_index;
          aw_error_n = aw_dec_error;
        end
        if (axi_in_wvalid && axi_in_wready) begin
          w_have_n = 1'b1;
          wdata_n  = axi_in_wdata;
          wstrb_n  = axi_in_wstrb;
        end
        // The *_n values already include anything captured this cycle, so
        // AW and W arriving together decide immediately.
        if (aw_have_n && w_have_n) begin
          aw_have_n = 1'b0;
          w_have_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          if (aw_error_n || (wstrb_n != 4'hF)) begin
            w_state_n = W_RESP;
            bvalid_n  = 1'b1;
            bresp_n   = RESP_SLVERR;
          end else begin
            w_state_n  = W_STREAM;
            wd_valid_n = 1'b1;
            wd_data_n  = wdata_n;
            wd_dest_n  = aw_index_n;
          end
        end else begin
          w_state_n = (aw_have_n || w_have_n) ? W_COLLECT : W_IDLE;
          awready_n = !aw_have_n;
          wready_n  = !w_have_n;
        end
      end
      W_STREAM: begin
        if (write_data_ready) begin
          wd_valid_n = 1'b0;
          w_state_n  = W_RESP;
          bvalid_n   = 1'b1;
          bresp_n    = RESP_OKAY;
        end
      end
      W_RESP: begin
        if (axi_in_bready) begin
          bvalid_n  = 1'b0;
          w_state_n = W_IDLE;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      write_state      <= W_IDLE;
      axi_in_awready   <= 1'b0;
      axi_in_wready    <= 1'b0;
      axi_in_bvalid    <= 1'b0;
      axi_in_bresp     <= 2'b00;
      write_data_valid <= 1'b0;
      write_data_data  <= '0;
      write_data_dest  <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      aw_index_q       <= '0;
      aw_error_q       <= 1'b0;
      aw_have_q        <= 1'b0;
      w_have_q         <= 1'b0;
    end else begin
      write_state      <= w_state_n;
      axi_in_awready   <= awready_n;
      axi_in_wready    <= wready_n;
      axi_in_bvalid    <= bvalid_n;
      axi_in_bresp     <= bresp_n;
      write_data_valid <= wd_valid_n;
      write_data_data  <= wd_data_n;
      write_data_dest  <= wd_dest_n;
      wdata_q          <= wdata_n;
      wstrb_q          <= wstrb_n;
      aw_index_q       <= aw_index_n;
      aw_error_q       <= aw_error_n;
      aw_have_q        <= aw_have_n;
      w_have_q         <= w_have_n;
    end
  end

  // ---------------- read side ----------------
  read_state_t           r_state_n;
  logic                  arready_n, rvalid_n, ra_valid_n;
  logic [1:0]            rresp_n;
  logic [31:0]           rdata_n;
  logic [DEST_WIDTH-1:0] ra_data_n;
  logic                  read_timeout;

  // Accepting in R_IDLE drains any late reply left over from an earlier read.
  assign read_data_ready = (read_state == R_IDLE) || (read_state == R_WAIT);

`ifdef AXIL_EXT_REGS_READ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timeout_count;

  always_ff @(posedge clock) begin
    if (!reset || (read_state != R_WAIT)) timeout_count <= '0;
    else                                  timeout_count <= timeout_count + TW'(1);
  end

  // High on the TIMEOUT_CYCLES-th clock spent in R_WAIT.
  assign read_timeout = (timeout_count == TW'(TIMEOUT_CYCLES - 1));
`else
  assign read_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    r_state_n  = read_state;
    arready_n  = axi_in_arready;
    rvalid_n   = axi_in_rvalid;
    rresp_n    = axi_in_rresp;
    rdata_n    = axi_in_rdata;
    ra_valid_n = read_address_valid;
    ra_data_n  = read_address_data;
    case (read_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (axi_in_arvalid && axi_in_arready) begin
          arready_n = 1'b0;
          if (ar_dec_error) begin
            r_state_n = R_RESP;
            rvalid_n  = 1'b1;
            rresp_n   = RESP_SLVERR;
            rdata_n   = '0;
          end else begin
            r_state_n  = R_REQ;
            ra_valid_n = 1'b1;
            ra_data_n  = ar_dec_index;
          end
        end
      end
      R_REQ: begin
        if (read_address_ready) begin
          ra_valid_n = 1'b0;
          r_state_n  = R_WAIT;
        end
      end
      R_WAIT: begin
        // A reply on the expiry cycle still wins.
        if (read_data_valid) begin
          r_state_n = R_RESP;
          rvalid_n  = 1'b1;
          rresp_n   = RESP_OKAY;
          rdata_n   = read_data_data;
        end else if (read_timeout) begin
          r_state_n = R_RESP;
          rvalid_n  = 1'b1;
          rresp_n   = RESP_SLVERR;
          rdata_n   = '0;
        end
      end
      R_RESP: begin
        if (axi_in_rready) begin
          rvalid_n  = 1'b0;
          r_state_n = R_IDLE;
          arready_n = 1'b1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_state         <= R_IDLE;
      axi_in_arready     <= 1'b0;
      axi_in_rvalid      <= 1'b0;
      axi_in_rresp       <= 2'b00;
      axi_in_rdata       <= '0;
      read_address_valid <= 1'b0;
      read_address_data  <= '0;
    end else begin
      read_state         <= r_state_n;
      axi_in_arready     <= arready_n;
      axi_in_rvalid      <= rvalid_n;
      axi_in_rresp       <= rresp_n;
      axi_in_rdata       <= rdata_n;
      read_address_valid <= ra_valid_n;
      read_address_data  <= ra_data_n;
    end
  end

endmodule
